// File: rtl/spm_loader_pkg.sv
// rtl/spm_loader_pkg.sv - shared types and constants for the SPM byte-stream loader
// SPM_LOADER_CHKSUM_EN adds the trailing checksum state.
package spm_loader_pkg;

   localparam int SPM_AW_DEF      = 12;      // mirrors SpmAddrBus in spm.vh
   localparam int HDR_LEN         = 4;
   localparam int TIMEOUT_CYC_DEF = 1000000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_CNT_HI,
      ST_CNT_LO,
      ST_DATA
`ifdef SPM_LOADER_CHKSUM_EN
      , ST_CHK
`endif
   } state_t;

endpackage

// File: rtl/spm_loader_if.sv
// rtl/spm_loader_if.sv - byte stream in, SPM port B write bus out
interface spm_loader_if
   import spm_loader_pkg::*;
#(
   parameter int AW = SPM_AW_DEF
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [AW-1:0] spm_addr;
   logic [31:0]   spm_wr_data;
   logic          spm_we;

   modport master (input rx_data, rx_valid, output spm_addr, spm_wr_data, spm_we);
   modport slave  (output rx_data, rx_valid, input spm_addr, spm_wr_data, spm_we);
endinterface

// File: rtl/spm_word_packer.sv
// rtl/spm_word_packer.sv - packs big-endian bytes into 32-bit words
module spm_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_done
);
   logic [1:0]  idx;
   logic [23:0] sr;

   // The fourth byte completes the word in the same cycle it arrives.
   assign word_done = byte_valid && (idx == 2'd3);
   assign word      = {sr, byte_data};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx <= 2'd0;
         sr  <= '0;
      end else if (clear) begin
         idx <= 2'd0;
         sr  <= '0;
      end else if (byte_valid) begin
         idx <= idx + 2'd1;
         sr  <= {sr[15:0], byte_data};
      end
   end
endmodule

// File: rtl/spm_loader.sv
// rtl/spm_loader.sv - header-parsing UART-to-SPM port B loader
// Define SPM_LOADER_CHKSUM_EN for a trailing XOR checksum byte.
module spm_loader
   import spm_loader_pkg::*;
#(
   parameter int SPM_AW      = SPM_AW_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   spm_loader_if.master    bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t            state;
   logic [7:0]        hdr_hi;
   logic [SPM_AW-1:0] cur_addr;
   logic [15:0]       remaining;
   logic [TW-1:0]     tmr;
   logic [31:0]       word;
   logic              word_done;
   logic              frame_end;
   logic [15:0]       cnt16;
`ifdef SPM_LOADER_CHKSUM_EN
   logic [7:0]        chk_acc;
`endif

   assign cnt16     = {hdr_hi, bus.rx_data};
   assign frame_end = (state == ST_CNT_LO && cnt16 == 16'd0) ||
                      (state == ST_DATA && word_done && remaining == 16'd1);

   spm_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (state != ST_DATA),
      .byte_valid (bus.rx_valid && state == ST_DATA),
      .byte_data  (bus.rx_data),
      .word       (word),
      .word_done  (word_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         hdr_hi          <= '0;
         cur_addr        <= '0;
         remaining       <= '0;
         tmr             <= '0;
         bus.spm_we      <= 1'b0;
         bus.spm_addr    <= '0;
         bus.spm_wr_data <= '0;
`ifdef SPM_LOADER_CHKSUM_EN
         chk_acc         <= '0;
`endif
      end else begin
         done       <= 1'b0;
         bus.spm_we <= 1'b0;
         if (state == ST_IDLE) begin
            tmr <= '0;
            if (start) begin
               state <= ST_ADDR_HI;
               busy  <= 1'b1;
               err   <= 1'b0;
`ifdef SPM_LOADER_CHKSUM_EN
               chk_acc <= '0;
`endif
            end
         end else if (!bus.rx_valid && tmr == TW'(TIMEOUT_CYC - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
         end else begin
            tmr <= bus.rx_valid ? '0 : tmr + 1'b1;
            if (bus.rx_valid) begin
               unique case (state)
                  ST_ADDR_HI: begin
                     hdr_hi <= bus.rx_data;
                     state  <= ST_ADDR_LO;
                  end
                  ST_ADDR_LO: begin
                     cur_addr <= SPM_AW'({hdr_hi, bus.rx_data});
                     state    <= ST_CNT_HI;
                  end
                  ST_CNT_HI: begin
                     hdr_hi <= bus.rx_data;
                     state  <= ST_CNT_LO;
                  end
                  ST_CNT_LO: begin
                     remaining <= cnt16;
                     state     <= ST_DATA;
                  end
                  ST_DATA: begin
`ifdef SPM_LOADER_CHKSUM_EN
                     chk_acc <= chk_acc ^ bus.rx_data;
`endif
                     if (word_done) begin
                        bus.spm_we      <= 1'b1;
                        bus.spm_addr    <= cur_addr;
                        bus.spm_wr_data <= word;
                        cur_addr        <= cur_addr + 1'b1;
                        remaining       <= remaining - 16'd1;
                     end
                  end
`ifdef SPM_LOADER_CHKSUM_EN
                  ST_CHK: begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     if (bus.rx_data == chk_acc) done <= 1'b1;
                     else                        err  <= 1'b1;
                  end
`endif
                  default: state <= ST_IDLE;
               endcase
               // Frame-end handling overrides the per-state next state above.
               if (frame_end) begin
`ifdef SPM_LOADER_CHKSUM_EN
                  state <= ST_CHK;
`else
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spm_loader.sv
// tb/tb_spm_loader.sv - self-checking bench for spm_loader against a frame-level model
module tb_spm_loader;
   import spm_loader_pkg::*;

   localparam int TO = 40;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy, done, err;

   spm_loader_if #(.AW(12)) bus ();

   spm_loader #(.SPM_AW(12), .TIMEOUT_CYC(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [43:0] got[$];
   int          done_cnt = 0;
   logic [7:0]  pl[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.spm_we) got.push_back({bus.spm_addr, bus.spm_wr_data});
         if (done) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic fill_rand(input int n);
      pl.delete();
      repeat (4 * n) pl.push_back(8'($urandom));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"},  err, 0);
      chk({tag, "_we"},   bus.spm_we, 0);
      chk({tag, "_addr"}, bus.spm_addr, 0);
      chk({tag, "_wdat"}, bus.spm_wr_data, 0);
   endtask

   // Runs one frame from payload pl; the model derives writes from address/index arithmetic.
   task automatic frame(input logic [15:0] a, input int n, input bit bad, input bit mid_start);
      logic [7:0]  hdr[HDR_LEN];
      logic [15:0] nn;
      logic [7:0]  x;
      logic [31:0] w;
      int          ea;
      int          d0;
      nn = n[15:0];
      hdr[0] = a[15:8]; hdr[1] = a[7:0]; hdr[2] = nn[15:8]; hdr[3] = nn[7:0];
      got.delete();
      d0 = done_cnt;
      pulse_start();
      chk("busy_on", busy, 1);
      chk("err_clr", err, 0);
      for (int i = 0; i < HDR_LEN; i++) send_byte(hdr[i], $urandom_range(0, 2));
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         if (mid_start && i == 1) pulse_start();
         x ^= pl[i];
         send_byte(pl[i], $urandom_range(0, 2));
      end
`ifdef SPM_LOADER_CHKSUM_EN
      chk("pre_chk_busy", busy, 1);
      send_byte(x ^ {7'b0, bad}, 1);
`endif
      chk("done", done, {63'b0, !bad});
      chk("busy_off", busy, 0);
      chk("err", err, {63'b0, bad});
      tick();
      tick();
      chk("done_cnt", done_cnt - d0, bad ? 0 : 1);
      chk("n_writes", got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         ea = (int'(a) + i) % 4096;
         w  = {pl[4*i], pl[4*i+1], pl[4*i+2], pl[4*i+3]};
         chk($sformatf("write%0d", i), got[i], {ea[11:0], w});
      end
   endtask

   initial begin
      int d0;
      reset        = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) tick();
      check_zero("rst");
      reset = 1'b0;
      tick();

      repeat (3) send_byte(8'($urandom), 0);
      chk("idle_drop_busy", busy, 0);
      chk("idle_drop_wr", got.size(), 0);

      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      frame(16'h0010, 2, 1'b0, 1'b0);
      fill_rand(2);
      frame(16'h0FFF, 2, 1'b0, 1'b0);
      fill_rand(1);
      frame(16'hF005, 1, 1'b0, 1'b1);
      pl.delete();
      frame(16'h0123, 0, 1'b0, 1'b0);
      fill_rand(3);
      frame(16'($urandom), 3, 1'b0, 1'b0);

      got.delete();
      d0 = done_cnt;
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      repeat (TO - 3) tick();
      chk("to_not_yet", busy, 1);
      repeat (8) tick();
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      chk("to_nowr", got.size(), 0);
      chk("to_nodone", done_cnt - d0, 0);
      fill_rand(1);
      frame(16'h0200, 1, 1'b0, 1'b0);

`ifdef SPM_LOADER_CHKSUM_EN
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      frame(16'h0040, 1, 1'b0, 1'b0);
      frame(16'h0041, 1, 1'b1, 1'b0);
`endif

      got.delete();
      pulse_start();
      send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
      reset = 1'b1;
      #1;
      check_zero("rst_mid");
      tick();
      reset = 1'b0;
      send_byte(8'hEF, 0);
      tick();
      chk("rst_mid_nowr", got.size(), 0);
      chk("rst_mid_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/spm_loader.md
# spm_loader

Byte-stream loader that fills the scratch-pad memory through its port B. Sits between the UART receiver (upstream, one byte per `rx_valid` strobe) and the SPM dual-port RAM (downstream). After a `start` pulse it parses a fixed header (start address, word count), packs big-endian bytes into 32-bit words, and issues one write per completed word. The CPU keeps port A of the SPM throughout.

## Interface
- `SPM_AW`, 12: SPM word-address width; matches `SpmAddrBus`.
- `TIMEOUT_CYC`, 1000000: idle cycles allowed between bytes inside a frame before abort.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle arm pulse; honoured only when `busy`=0.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse on successful frame end.
- `err` out 1: sticky frame error (timeout or checksum); cleared by the next accepted `start`.
- `spm_addr` out `SPM_AW`: port B word address.
- `spm_wr_data` out 32: port B write data.
- `spm_we` out 1: port B write enable, one cycle per word.

## Operation
- Frame bytes, in order: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 4×N data bytes, most-significant byte first.
- Only the low `SPM_AW` bits of the 16-bit address are used. Upper bits are ignored.
- States: IDLE → ADDR_HI → ADDR_LO → CNT_HI → CNT_LO → DATA → (CHK) → IDLE.
- Each header state advances on `rx_valid`.
- IDLE→ADDR_HI on `start`; sets `busy`, clears `err`. `rx_valid` in IDLE is dropped.
- CNT_LO with N=0: skip DATA. Go to CHK if compiled in, otherwise go to IDLE and pulse `done`.
- DATA: a 2-bit byte index shifts bytes into a 32-bit packer.
- On the 4th byte, register the word. Pulse `spm_we` with the current address, then increment the address modulo 2^`SPM_AW` (wraps 0xFFF→0x000) and decrement the remaining count.
- After the last word: go to CHK, or go to IDLE with `done`.
- `start` while `busy` is ignored.
- Timeout: in any non-IDLE state, a counter clears on each `rx_valid`. When it reaches `TIMEOUT_CYC`: set `err`, go to IDLE, no `done`, drop the partial word. Words already written stay written.
- No backpressure: every `rx_valid` is consumed in its cycle. Consecutive strobes on back-to-back cycles are legal.
- Reset mid-frame: immediate return to IDLE. All outputs take reset values. A partial word is never written.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `spm_we`=0, `spm_addr`=0, `spm_wr_data`=0.
- All outputs are registered.
- `spm_we` is high in the cycle after the 4th byte's `rx_valid`.
- `spm_addr` and `spm_wr_data` are valid in that cycle and hold until the next write.
- `done` is high, and `busy` low, in the cycle after the final qualifying `rx_valid` (last data byte or checksum byte). If the last word's write and `done` coincide, they occur in the same cycle.
- The first header byte may arrive in the cycle after `start`.
- Same-address collisions with CPU port A writes are resolved by the SPM forwarding. The loader does not check for them.

## Configuration
- `SPM_LOADER_CHKSUM_EN` defined:
  - CHK state expects one trailing byte equal to the XOR of all 4N data bytes.
  - Mismatch: `err`=1, no `done`; written words are not rolled back.
  - Match: `done`.
  - For N=0 the expected value is 0x00.
- Undefined: no CHK state, no XOR register; the frame ends after the last data byte.

## Structure
- Shared package/header holds:
  - state encoding;
  - header length (4);
  - `TIMEOUT_CYC` default;
  - SPM address width taken from `spm.vh`.
- One natural sub-module: `spm_word_packer`. It holds the byte index, the shift register and the word-complete strobe, and has a clear input for abort and reset.

## Test plan
- Header 0x0010/0x0002, data 11 22 33 44 55 66 77 88 → writes 0x11223344@0x010 and 0x55667788@0x011, then `done`.
- Address 0x0FFF, N=2 → writes at 0x0FFF then 0x000 (wrap). Address 0xF005 → first write at 0x005.
- N=0 → no `spm_we`; `done` (with checksum: after byte 0x00).
- Stall `TIMEOUT_CYC` cycles after two data bytes → `err`=1, `busy`=0, no write. Next `start` clears `err`.
- `SPM_LOADER_CHKSUM_EN`, data 01 02 03 04, chk 0x04 → `done`. With chk 0x05 → `err`, word still written.
- Assert `reset` between the 3rd and 4th data byte → no `spm_we`, all outputs 0. `start` mid-frame is ignored.
